// File: rtl/packet_pkg.sv
// Shared definitions for the packet transmit path.
//   PACKET_BYTES : fixed packet length in bytes
//   ADDR_W       : byte index width
//   state_t      : arbiter FSM states
//   SRC_KEYX / SRC_VOICE : requester identifiers (bit position in req/grant/commit/sent)
package packet_pkg;

    localparam int unsigned PACKET_BYTES = 64;
    localparam int unsigned ADDR_W       = $clog2(PACKET_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LOAD,
        SEND
    } state_t;

    localparam logic SRC_KEYX  = 1'b0;
    localparam logic SRC_VOICE = 1'b1;

endpackage

// File: rtl/packet_buffer.sv
// Single outgoing packet store: PACKET_BYTES x 8, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
//   clock   : write clock
//   we_i    : write enable
//   waddr_i : write byte index
//   wdata_i : write byte
//   raddr_i : read byte index
//   rdata_o : byte at raddr_i (combinational)
module packet_buffer
    import packet_pkg::*;
(
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [PACKET_BYTES];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_tx_arbiter.sv
// Arbitrates ownership of the single packet buffer between the key-exchange
// sender (source 0) and the voice packetizer (source 1), then streams the
// committed packet bytewise to the link transmitter.
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   req[1:0]               : per-source ownership request (level)
//   grant[1:0]             : one-hot ownership
//   wr_index_x/wr_data_x/wr_en_x : per-source buffer write port
//   commit[1:0]            : per-source pulse, packet complete
//   tx_data/tx_valid/tx_ready/tx_last : byte stream to transmitter
//   sent[1:0]              : per-source pulse after last byte accepted
//   busy                   : FSM not idle
module packet_tx_arbiter
    import packet_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    output logic [1:0]        grant,
    input  logic [ADDR_W-1:0] wr_index_0,
    input  logic [ADDR_W-1:0] wr_index_1,
    input  logic [7:0]        wr_data_0,
    input  logic [7:0]        wr_data_1,
    input  logic              wr_en_0,
    input  logic              wr_en_1,
    input  logic [1:0]        commit,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic [1:0]        sent,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PACKET_BYTES - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_served_q, last_served_d;
    logic [ADDR_W-1:0] tx_idx_q, tx_idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        sent_q, sent_d;

    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [7:0]        buf_wdata;
    logic [ADDR_W-1:0] buf_raddr;
    logic [7:0]        buf_rdata;
    logic              is_last;

    assign is_last = (tx_idx_q == LAST_IDX);

    // Only the owner's port reaches the buffer, and only while filling.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = wr_index_0;
        buf_wdata = wr_data_0;
        if (owner_q == SRC_VOICE) begin
            buf_waddr = wr_index_1;
            buf_wdata = wr_data_1;
        end
        if (state_q == FILL) begin
            buf_we = (owner_q == SRC_VOICE) ? wr_en_1 : wr_en_0;
        end
    end

    // Read port looks one byte ahead so tx_data can be reloaded on the
    // handshake edge; in LOAD it points at byte 0.
    assign buf_raddr = (state_q == SEND) ? tx_idx_q + 1'b1 : '0;

    packet_buffer u_buffer (
        .clock   (clock),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        tx_idx_d      = tx_idx_q;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        sent_d        = '0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    if (req == 2'b11) begin
                        owner_d = ~last_served_q;
                    end else begin
                        owner_d = req[1] ? SRC_VOICE : SRC_KEYX;
                    end
                    grant_d = (owner_d == SRC_VOICE) ? 2'b10 : 2'b01;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Commit takes precedence over a simultaneous req drop.
                if (commit[owner_q]) begin
                    state_d = LOAD;
                end else if (!req[owner_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                tx_data_d = buf_rdata;
                tx_idx_d  = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (is_last) begin
                        sent_d        = grant_q;
                        last_served_d = owner_q;
                        grant_d       = '0;
                        state_d       = IDLE;
                    end else begin
                        tx_idx_d  = tx_idx_q + 1'b1;
                        tx_data_d = buf_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= SRC_KEYX;
            last_served_q <= SRC_VOICE;
            tx_idx_q      <= '0;
            tx_data_q     <= '0;
            grant_q       <= '0;
            sent_q        <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            tx_idx_q      <= tx_idx_d;
            tx_data_q     <= tx_data_d;
            grant_q       <= grant_d;
            sent_q        <= sent_d;
        end
    end

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = (state_q == SEND);
    assign tx_last  = (state_q == SEND) && is_last;
    assign sent     = sent_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_packet_tx_arbiter.sv
module tb_packet_tx_arbiter;
    import packet_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] wr_index_0, wr_index_1;
    logic [7:0]        wr_data_0, wr_data_1;
    logic              wr_en_0, wr_en_1;
    logic [1:0]        commit;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic [1:0]        sent;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Reference model: buffer image, who owns it, who was served last.
    logic [7:0] model_mem [PACKET_BYTES];
    int         model_owner = -1;
    int         model_last  = 1;

    always #5 clock = ~clock;

    packet_tx_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .wr_index_0 (wr_index_0),
        .wr_index_1 (wr_index_1),
        .wr_data_0  (wr_data_0),
        .wr_data_1  (wr_data_1),
        .wr_en_0    (wr_en_0),
        .wr_en_1    (wr_en_1),
        .commit     (commit),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .sent       (sent),
        .busy       (busy)
    );

    task automatic write_byte(input int src, input int idx, input logic [7:0] data);
        if (src == 0) begin
            wr_en_0 = 1'b1; wr_index_0 = ADDR_W'(idx); wr_data_0 = data;
        end else begin
            wr_en_1 = 1'b1; wr_index_1 = ADDR_W'(idx); wr_data_1 = data;
        end
        @(negedge clock);
        wr_en_0 = 1'b0;
        wr_en_1 = 1'b0;
        if (src == model_owner) model_mem[idx] = data;
    endtask

    task automatic fill_random(input int src);
        for (int i = 0; i < PACKET_BYTES; i++) write_byte(src, i, 8'($urandom));
    endtask

    task automatic acquire(input logic [1:0] r, input string name);
        int         w;
        logic [1:0] exp_g;
        req = r;
        if (r == 2'b11) w = 1 - model_last;
        else            w = r[1] ? 1 : 0;
        exp_g = (w == 1) ? 2'b10 : 2'b01;
        @(negedge clock);
        checks++;
        if (grant !== exp_g || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s: grant=%b busy=%b, expected grant=%b busy=1", name, grant, busy, exp_g);
        end
        model_owner = w;
    endtask

    task automatic commit_pkt(input int src, input string name);
        commit[src] = 1'b1;
        @(negedge clock);
        commit = 2'b00;
        model_owner = -1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s: in LOAD tx_valid=%b busy=%b, expected 0/1", name, tx_valid, busy);
        end
    endtask

    // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready.
    // Random writes from both sources are thrown in; they must be ignored.
    task automatic drain_packet(input int src, input int mode, input int stop_at, input string name);
        logic [7:0] exp [PACKET_BYTES];
        logic       exp_last;
        logic       rdy;
        int         k = 0;
        int         cyc = 0;
        for (int i = 0; i < PACKET_BYTES; i++) exp[i] = model_mem[i];
        tx_ready = 1'b0;
        @(negedge clock);
        while (k < stop_at) begin
            if (cyc >= 1000) begin
                errors++; checks++;
                $display("FAIL %s_timeout: stuck at byte %0d, expected completion", name, k);
                break;
            end
            exp_last = (k == PACKET_BYTES - 1);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[k] || tx_last !== exp_last || sent !== 2'b00) begin
                errors++;
                $display("FAIL %s_byte%0d: valid=%b data=%h last=%b sent=%b, expected 1 %h %b 00",
                         name, k, tx_valid, tx_data, tx_last, sent, exp[k], exp_last);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready   = rdy;
            wr_en_0    = 1'($urandom_range(0, 1));
            wr_en_1    = 1'($urandom_range(0, 1));
            wr_index_0 = ADDR_W'($urandom_range(0, PACKET_BYTES - 1));
            wr_index_1 = ADDR_W'($urandom_range(0, PACKET_BYTES - 1));
            wr_data_0  = 8'($urandom);
            wr_data_1  = 8'($urandom);
            @(negedge clock);
            cyc++;
            if (rdy) k++;
        end
        wr_en_0  = 1'b0;
        wr_en_1  = 1'b0;
        tx_ready = 1'b0;
        if (stop_at == PACKET_BYTES) begin
            checks++;
            if (sent !== ((src == 1) ? 2'b10 : 2'b01) || grant !== 2'b00 || busy !== 1'b0 ||
                tx_valid !== 1'b0 || tx_last !== 1'b0) begin
                errors++;
                $display("FAIL %s_end: sent=%b grant=%b busy=%b valid=%b last=%b, expected sent one-hot src%0d, rest 0",
                         name, sent, grant, busy, tx_valid, tx_last, src);
            end
            model_last  = src;
            model_owner = -1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (grant !== 2'b00 || tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00 ||
            sent !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: grant=%b valid=%b last=%b data=%h sent=%b busy=%b, expected all 0",
                     grant, tx_valid, tx_last, tx_data, sent, busy);
        end
        reset = 1'b0;
        commit = 2'b11;
        @(negedge clock);
        commit = 2'b00;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL commit_no_grant: busy=%b grant=%b valid=%b, expected 0 0 0", busy, grant, tx_valid);
        end
    endtask

    task automatic test_round_robin;
        for (int r = 0; r < 3; r++) begin
            acquire(2'b11, $sformatf("rr_grant%0d", r));
            checks++;
            if (sent !== 2'b00) begin
                errors++;
                $display("FAIL rr_sent_pulse%0d: sent=%b, expected 00", r, sent);
            end
            fill_random(model_owner);
            commit_pkt(model_owner, "rr_commit");
            drain_packet(model_last == 0 ? 1 : 0, 2, PACKET_BYTES, "rr");
        end
        req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_single_source;
        acquire(2'b01, "single_grant");
        for (int i = 0; i < PACKET_BYTES; i++) write_byte(0, i, 8'(8'hA0 + i));
        commit_pkt(0, "single_commit");
        drain_packet(0, 0, PACKET_BYTES, "single");
        req = 2'b00;
        @(negedge clock);
        checks++;
        if (sent !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: sent=%b busy=%b, expected 00 0", sent, busy);
        end
    endtask

    task automatic test_backpressure;
        acquire(2'b01, "bp_grant");
        fill_random(0);
        commit_pkt(0, "bp_commit");
        drain_packet(0, 1, PACKET_BYTES, "bp");
        req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_interference;
        logic [7:0] d;
        acquire(2'b10, "intf_grant");
        for (int i = 0; i < PACKET_BYTES; i++) begin
            d = 8'($urandom);
            wr_en_0 = 1'b1; wr_index_0 = ADDR_W'(i); wr_data_0 = 8'hFF;
            wr_en_1 = 1'b1; wr_index_1 = ADDR_W'(i); wr_data_1 = d;
            commit[0] = (i == 20);
            @(negedge clock);
            model_mem[i] = d;
        end
        wr_en_0 = 1'b0; wr_en_1 = 1'b0; commit = 2'b00;
        @(negedge clock);
        checks++;
        if (grant !== 2'b10 || busy !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL intf_commit0_ignored: grant=%b busy=%b valid=%b, expected 10 1 0", grant, busy, tx_valid);
        end
        commit_pkt(1, "intf_commit");
        drain_packet(1, 2, PACKET_BYTES, "intf");
        req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_abort;
        acquire(2'b10, "abort_grant");
        req = 2'b11;
        for (int i = 0; i < 10; i++) write_byte(1, i, 8'($urandom));
        req = 2'b01;
        model_owner = -1;
        @(negedge clock);
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || tx_valid !== 1'b0 || sent !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: grant=%b busy=%b valid=%b sent=%b, expected 00 0 0 00",
                     grant, busy, tx_valid, sent);
        end
        acquire(2'b01, "abort_next_grant");
        fill_random(0);
        commit_pkt(0, "abort_commit");
        drain_packet(0, 0, PACKET_BYTES, "abort_pkt");
        req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_send;
        acquire(2'b01, "rst_grant");
        fill_random(0);
        commit_pkt(0, "rst_commit");
        drain_packet(0, 0, 30, "rst_partial");
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00 || tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00 ||
            sent !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_send: grant=%b valid=%b last=%b data=%h sent=%b busy=%b, expected all 0",
                     grant, tx_valid, tx_last, tx_data, sent, busy);
        end
        req = 2'b00;
        model_last  = 1;
        model_owner = -1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        acquire(2'b01, "rst_regrant");
        fill_random(0);
        commit_pkt(0, "rst_recommit");
        drain_packet(0, 2, PACKET_BYTES, "rst_fresh");
        req = 2'b00;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; commit = 2'b00; tx_ready = 1'b0;
        wr_en_0 = 1'b0; wr_en_1 = 1'b0;
        wr_index_0 = '0; wr_index_1 = '0; wr_data_0 = '0; wr_data_1 = '0;
        for (int i = 0; i < PACKET_BYTES; i++) model_mem[i] = 8'h00;

        test_reset;
        test_round_robin;
        test_single_source;
        test_backpressure;
        test_interference;
        test_abort;
        test_reset_mid_send;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
